// File: rtl/bin_to_bcd_sequencer_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_sequencer_if
//
// Groups the conversion handshake and the digit/blink display bus of
// bin_to_bcd_sequencer.
//
//   master : drives iStart/iBin (and iHex when BCD_HEX_BYPASS_EN is defined),
//            observes oBusy/oDone/oDigit0..3/oBlink.
//   slave  : the converter; the mirror image of master.
//
// Parameter WIDTH : bit width of iBin (legal 4..14).
// Macro BCD_HEX_BYPASS_EN : adds the iHex select line.
// ---------------------------------------------------------------------------
interface bin_to_bcd_sequencer_if #(
    parameter int WIDTH = 14
);
    logic             iStart;
    logic [WIDTH-1:0] iBin;
`ifdef BCD_HEX_BYPASS_EN
    logic             iHex;
`endif
    logic             oBusy;
    logic             oDone;
    logic [3:0]       oDigit0;
    logic [3:0]       oDigit1;
    logic [3:0]       oDigit2;
    logic [3:0]       oDigit3;
    logic             oBlink;

`ifdef BCD_HEX_BYPASS_EN
    modport master (
        output iStart, iBin, iHex,
        input  oBusy, oDone, oDigit0, oDigit1, oDigit2, oDigit3, oBlink
    );
    modport slave (
        input  iStart, iBin, iHex,
        output oBusy, oDone, oDigit0, oDigit1, oDigit2, oDigit3, oBlink
    );
`else
    modport master (
        output iStart, iBin,
        input  oBusy, oDone, oDigit0, oDigit1, oDigit2, oDigit3, oBlink
    );
    modport slave (
        input  iStart, iBin,
        output oBusy, oDone, oDigit0, oDigit1, oDigit2, oDigit3, oBlink
    );
`endif

endinterface : bin_to_bcd_sequencer_if

// File: rtl/bin_to_bcd_sequencer.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_sequencer
//
// Sequential binary-to-BCD converter (shift-add-3 / double dabble), one
// iteration per clock. Feeds the per-digit seven-segment controllers: the
// four digits and the blink request are held stable between conversions and
// only change in the cycle oDone is high.
//
// Ports:
//   iClk  : clock, rising edge
//   nRst  : asynchronous active-low reset
//   bus   : bin_to_bcd_sequencer_if.slave
//             iStart/iBin (iHex)     conversion request, sampled in IDLE only
//             oBusy                  high while CONVERT is running
//             oDone                  one-cycle completion pulse
//             oDigit0..3             BCD ones..thousands
//             oBlink                 overflow (value > 9999, shown as 9999)
//
// Parameter WIDTH : input width, legal 4..14.
// Macro BCD_HEX_BYPASS_EN : when defined, iHex=1 displays iBin as four hex
//   nibbles immediately (no CONVERT, oDone next cycle, no saturation).
// ---------------------------------------------------------------------------
module bin_to_bcd_sequencer #(
    parameter int WIDTH = 14
) (
    input  logic                         iClk,
    input  logic                         nRst,
    bin_to_bcd_sequencer_if.slave        bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [15:0]      scratch_q, scratch_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      digits_q, digits_d;
    logic             blink_q, blink_d;
    logic             done_q, done_d;

    logic [15:0]      bin_ext;       // iBin zero-extended to four nibbles
    logic [15:0]      adjusted;      // scratch after the add-3 step
    logic [15:0]      scratch_next;  // scratch after adjust + shift
    logic             hex_sel;
    logic             busy;

    assign bin_ext = {{(16 - WIDTH){1'b0}}, bus.iBin};

`ifdef BCD_HEX_BYPASS_EN
    assign hex_sel = bus.iHex;
`else
    assign hex_sel = 1'b0;
`endif

    // One double-dabble iteration on the current (pre-iteration) scratch:
    // every nibble >= 5 gets +3 so the following doubling carries into the
    // next decimal digit, then the shift register's MSB enters at the bottom.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            adjusted[4*n +: 4] = (scratch_q[4*n +: 4] >= 4'd5)
                               ? scratch_q[4*n +: 4] + 4'd3
                               : scratch_q[4*n +: 4];
        end
        scratch_next = {adjusted[14:0], shift_q[WIDTH-1]};
    end

    // -----------------------------------------------------------------------
    // Process 1: state and datapath registers.
    // -----------------------------------------------------------------------
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            digits_q  <= '0;
            blink_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            digits_q  <= digits_d;
            blink_q   <= blink_d;
            done_q    <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state logic.
    // -----------------------------------------------------------------------
    // NOTE: each combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.iStart && !hex_sel) state_d = CONVERT;
            CONVERT: if (cnt_q == 4'd1)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Process 3: datapath next values and outputs.
    // Displayed digits/blink hold unless a conversion completes this edge.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        ovf_d     = ovf_q;
        digits_d  = digits_q;
        blink_d   = blink_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    if (hex_sel) begin
                        // Hex bypass: show the nibbles straight away.
                        digits_d = bin_ext;
                        blink_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        shift_d   = bus.iBin;
                        scratch_d = '0;
                        cnt_d     = 4'(WIDTH);
                        ovf_d     = (bin_ext > 16'd9999);
                    end
                end
            end
            CONVERT: begin
                scratch_d = scratch_next;
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // Saturate to 9999 when the input exceeded four digits.
                    digits_d = ovf_q ? 16'h9999 : scratch_next;
                    blink_d  = ovf_q;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q == CONVERT);

    assign bus.oBusy   = busy;
    assign bus.oDone   = done_q;
    assign bus.oDigit0 = digits_q[3:0];
    assign bus.oDigit1 = digits_q[7:4];
    assign bus.oDigit2 = digits_q[11:8];
    assign bus.oDigit3 = digits_q[15:12];
    assign bus.oBlink  = blink_q;

endmodule : bin_to_bcd_sequencer

// File: doc/bin_to_bcd_sequencer.md
# bin_to_bcd_sequencer

Sequential binary-to-decimal converter that sits directly upstream of the per-digit seven-segment controllers. It accepts an unsigned binary value on a start/busy/done handshake and converts it to four BCD digits with the shift-add-3 (double-dabble) algorithm, one iteration per clock. It holds the digits and a blink request stable between conversions, so each seven-segment controller can take its 4-bit digit and blink enable straight from this block.

## Interface
- WIDTH, 14, bit width of the binary input; legal range 4..14.
- iClk  input  1  clock, rising edge.
- nRst  input  1  asynchronous, active-low reset.
- iBin  input  WIDTH  unsigned binary value; sampled only on an accepted start.
- iStart  input  1  conversion request; accepted only in IDLE.
- oBusy  output  1  high while a conversion is in progress.
- oDone  output  1  one-cycle pulse; digits and oBlink are updated in the same cycle.
- oDigit0  output  4  BCD ones digit, to the ones-position seven-segment controller.
- oDigit1  output  4  BCD tens digit.
- oDigit2  output  4  BCD hundreds digit.
- oDigit3  output  4  BCD thousands digit.
- oBlink  output  1  overflow indication, wired to the seven-segment controllers' blink enable.

## Operation
- States: IDLE and CONVERT.
- **IDLE:** on an edge with iStart=1:
  - capture iBin, zero-extended, into the shift register;
  - clear the 16-bit BCD scratch;
  - load the iteration counter with WIDTH;
  - latch ovf = (iBin > 9999);
  - go to CONVERT, oBusy=1.
- **CONVERT:** each edge performs one iteration:
  - add 3 to every scratch nibble that is ≥5;
  - shift {scratch, shift register} left by 1;
  - decrement the counter.
- **Final iteration (counter=1):** the same edge:
  - writes the digits: scratch result, or 9,9,9,9 if ovf;
  - sets oBlink=ovf;
  - pulses oDone=1, clears oBusy and returns to IDLE.
- The digit adjust and shift use the pre-iteration scratch value, computed combinationally within the cycle.
- iStart is ignored while oBusy=1. iBin changes after capture have no effect.
- oDigit0..3 and oBlink hold their last values until the next oDone. They never show partial results.
- Digits are always 0..9 in decimal mode.
- Saturation applies only when WIDTH=14, since smaller widths cannot exceed 9999.

## Timing
- Reset values:
  - oDigit0..3 = 0;
  - oBlink = 0, oBusy = 0, oDone = 0;
  - state IDLE, counter 0.
- nRst asserted mid-conversion aborts immediately to the reset values. No oDone is produced.
- Latency: start accepted at edge E0; iterations occur at E1..E_WIDTH; oDone, digits and oBlink become valid after E_WIDTH.
  - For WIDTH=14, oDone is high during the cycle after E14.
- oBusy is high for exactly WIDTH cycles per conversion.
- oDone is high for exactly one cycle.
- Back-to-back: the cycle in which oDone=1 is IDLE, so iStart=1 in that cycle is accepted.
  - Sustained throughput is one conversion per WIDTH+1 cycles.
- iStart coincident with the final iteration edge is not accepted; it is accepted on the following edge if still high.

## Configuration
- Macro: BCD_HEX_BYPASS_EN.
- **Defined:**
  - adds input port iHex (1 bit), sampled together with iBin on start;
  - iHex=1 skips CONVERT: at the start edge, oDigitN = iBin[4N+3:4N] (zero-extended), oBlink=0 and there is no saturation;
  - oDone pulses the following cycle and oBusy never rises;
  - iHex=0 behaves exactly as decimal mode.
- **Undefined:** the iHex port is absent and every conversion is decimal.

## Test plan
- **Basic conversion:** reset, then iBin=1234 with a one-cycle iStart.
  - oBusy high for 14 cycles, oDone pulse 15 edges after the start edge.
  - Digits 4,3,2,1 (ones first), oBlink=0.
- **Boundaries and saturation:** convert 0, 9999, 10000 and 16383, then 42.
  - 0 gives 0,0,0,0; 9999 gives 9,9,9,9 with oBlink=0.
  - 10000 and 16383 give 9,9,9,9 with oBlink=1.
  - 42 gives 2,4,0,0 with oBlink cleared at its oDone.
- **Sustained start:** iStart held high, iBin changed every cycle.
  - Each result matches the value present at its accepted start edge.
  - oDone pulses every 15 cycles; digits never change outside oDone cycles.
- **Reset mid-conversion:** nRst pulsed low during iteration 7 of 1234, after the prior result 5678 is displayed.
  - All outputs return to 0 asynchronously, with no oDone.
  - The next start with 77 yields 7,7,0,0.
- **Hex bypass (BCD_HEX_BYPASS_EN defined):** iHex=1, iBin=14'h2BCD.
  - oDone one cycle after the start edge, oBusy stays 0.
  - Digits D,C,B,2, oBlink=0.
  - Then iHex=0, iBin=321 gives 1,2,3,0 after 15 edges.
